// File: rtl/lcd_char_queue_pkg.sv
// Shared field widths, entry layout and FSM encoding for the LCD character queue.
package lcd_char_queue_pkg;

   localparam int unsigned ASCII_W = 8;
   localparam int unsigned COORD_W = 9;
   localparam int unsigned COLOR_W = 16;
   localparam int unsigned ENTRY_W = ASCII_W + 2 * COORD_W + 1 + 2 * COLOR_W;

   localparam logic FONT_12X6 = 1'b0;
   localparam logic FONT_16X8 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic [ASCII_W-1:0] ascii;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               size;
      logic [COLOR_W-1:0] fg;
      logic [COLOR_W-1:0] bg;
   } char_entry_t;

   function automatic char_entry_t pack_entry(
      input logic [ASCII_W-1:0] ascii,
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic               size,
      input logic [COLOR_W-1:0] fg,
      input logic [COLOR_W-1:0] bg
   );
      char_entry_t e;
      e.ascii = ascii;
      e.x     = x;
      e.y     = y;
      e.size  = size ? FONT_16X8 : FONT_12X6;
      e.fg    = fg;
      e.bg    = bg;
      return e;
   endfunction

endpackage

// File: rtl/lcd_char_queue_fifo.sv
// Generic synchronous FIFO with flush and an occupancy count; not_full is a
// registered view of the next occupancy so it never lags the level.
module char_fifo_sync #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [LW-1:0]    level,
   output logic             not_full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_next;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && not_full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      level_next = level;
      if (flush) begin
         level_next = '0;
      end else if (do_push && !do_pop) begin
         level_next = level + LW'(1);
      end else if (do_pop && !do_push) begin
         level_next = level - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         not_full <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         level    <= level_next;
         not_full <= (level_next != LW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/lcd_char_queue.sv
// Queues character draw requests and issues them one at a time to lcd_show_char.
// Optional watchdog on the renderer handshake: define LCD_CHAR_QUEUE_TIMEOUT_EN.
module lcd_char_queue #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             init_done,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_ascii,
   input  logic [8:0]       req_x,
   input  logic [8:0]       req_y,
   input  logic             req_size,
   input  logic [15:0]      req_fg,
   input  logic [15:0]      req_bg,
   input  logic             show_char_done,
   output logic             show_char_flag,
   output logic [7:0]       ascii_num,
   output logic [8:0]       start_x,
   output logic [8:0]       start_y,
   output logic             en_size,
   output logic [15:0]      front_color,
   output logic [15:0]      background_color,
   output logic [LVL_W-1:0] level,
   output logic             busy,
   output logic             timeout_err
);

   import lcd_char_queue_pkg::*;

   localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
      $error("lcd_char_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
   end

   state_t      state;
   state_t      state_next;
   logic [GW-1:0] gap_cnt;
   logic        pop;
   logic        fifo_empty;
   logic        wd_expired;
   char_entry_t push_entry;
   char_entry_t head;

   assign push_entry = pack_entry(req_ascii, req_x, req_y, req_size, req_fg, req_bg);

   char_fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .flush     (flush),
      .push      (req_valid),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .level     (level),
      .not_full  (req_ready),
      .empty     (fifo_empty)
   );

   assign busy = (state != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_next     = state;
      pop            = 1'b0;
      show_char_flag = 1'b0;
      case (state)
         ST_IDLE: begin
            if (init_done && !fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            show_char_flag = 1'b1;
            state_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (show_char_done || wd_expired) state_next = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt <= GW'(1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output fields load only on a pop, so they stay stable through ISSUE/WAIT/GAP
   // even when the queue behind them is flushed or refilled.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state            <= ST_IDLE;
         gap_cnt          <= '0;
         ascii_num        <= '0;
         start_x          <= '0;
         start_y          <= '0;
         en_size          <= 1'b0;
         front_color      <= '0;
         background_color <= '0;
      end else begin
         state <= state_next;
         if (state == ST_WAIT && state_next == ST_GAP) begin
            gap_cnt <= GW'(GAP_CYCLES);
         end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
         if (pop) begin
            ascii_num        <= head.ascii;
            start_x          <= head.x;
            start_y          <= head.y;
            en_size          <= head.size;
            front_color      <= head.fg;
            background_color <= head.bg;
         end
      end
   end

`ifdef LCD_CHAR_QUEUE_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ST_WAIT && !show_char_done && !wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end else begin
            wd_cnt <= '0;
         end
         if (state == ST_WAIT && !show_char_done && wd_expired) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign wd_expired  = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_char_queue.sv
// Directed self-checking bench for lcd_char_queue (table-driven plus corner sequences).
module tb_lcd_char_queue;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH + 1);
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   localparam logic [58:0] Z     = '0;
   localparam logic [58:0] ENT_A = {8'h41, 9'd8,   9'd16,  1'b1, 16'hFFFF, 16'h0000};
   localparam logic [58:0] ENT_B = {8'h42, 9'd1,   9'd2,   1'b0, 16'h1234, 16'h5678};
   localparam logic [58:0] ENT_C = {8'h43, 9'd3,   9'd4,   1'b1, 16'hAAAA, 16'h5555};
   localparam logic [58:0] ENT_D = {8'h44, 9'd300, 9'd200, 1'b0, 16'hF800, 16'h07E0};
   localparam logic [58:0] ENT_E = {8'h45, 9'd511, 9'd511, 1'b1, 16'h001F, 16'hFFFF};

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          init_done;
   logic          flush;
   logic          req_valid;
   logic          req_ready;
   logic [7:0]    req_ascii;
   logic [8:0]    req_x;
   logic [8:0]    req_y;
   logic          req_size;
   logic [15:0]   req_fg;
   logic [15:0]   req_bg;
   logic          show_char_done;
   logic          show_char_flag;
   logic [7:0]    ascii_num;
   logic [8:0]    start_x;
   logic [8:0]    start_y;
   logic          en_size;
   logic [15:0]   front_color;
   logic [15:0]   background_color;
   logic [LW-1:0] level;
   logic          busy;
   logic          timeout_err;

   int tests    = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   lcd_char_queue #(
      .DEPTH          (DEPTH),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .init_done        (init_done),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_ascii        (req_ascii),
      .req_x            (req_x),
      .req_y            (req_y),
      .req_size         (req_size),
      .req_fg           (req_fg),
      .req_bg           (req_bg),
      .show_char_done   (show_char_done),
      .show_char_flag   (show_char_flag),
      .ascii_num        (ascii_num),
      .start_x          (start_x),
      .start_y          (start_y),
      .en_size          (en_size),
      .front_color      (front_color),
      .background_color (background_color),
      .level            (level),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   typedef struct {
      logic          init;
      logic          flsh;
      logic          valid;
      logic          done;
      logic [58:0]   entry;
      logic          exp_flag;
      logic [LW-1:0] exp_level;
      logic          exp_ready;
      logic          exp_busy;
      logic [58:0]   exp_out;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive_entry(input logic [58:0] e);
      {req_ascii, req_x, req_y, req_size, req_fg, req_bg} = e;
   endtask

   function automatic logic [58:0] out_fields();
      return {ascii_num, start_x, start_y, en_size, front_color, background_color};
   endfunction

   function automatic logic [58:0] mk_ent(input int k);
      logic [15:0] c;
      c = 16'(k * 'h1111);
      return {8'(k + 'h30), 9'(k * 37), 9'(k * 13 + 5), 1'(k % 2), c, ~c};
   endfunction

   function automatic vec_t mk(input logic i, input logic f, input logic v, input logic d,
                               input logic [58:0] e, input logic fl, input int lv,
                               input logic rd, input logic bs, input logic [58:0] eo);
      vec_t r;
      r.init = i; r.flsh = f; r.valid = v; r.done = d; r.entry = e;
      r.exp_flag = fl; r.exp_level = LW'(lv); r.exp_ready = rd; r.exp_busy = bs; r.exp_out = eo;
      return r;
   endfunction

   // Ticks until an issue pulse is seen; n is the number of edges taken.
   task automatic wait_flag(input string name, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!show_char_flag && n < 50);
      if (!show_char_flag) begin
         tests++;
         failures++;
         $display("FAIL %s: no issue pulse within 50 cycles", name);
      end
   endtask

   task automatic count_flags(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (show_char_flag) cnt++;
      end
   endtask

   task automatic finish_char();
      tick();
      show_char_done = 1'b1;
      tick();
      show_char_done = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, got running, expected done");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int cnt;

      vecs[0]  = mk(T, F, T, F, ENT_A, F, 1, T, T, Z);
      vecs[1]  = mk(T, F, F, F, Z,     T, 0, T, T, ENT_A);
      vecs[2]  = mk(T, F, F, F, Z,     F, 0, T, T, ENT_A);
      vecs[3]  = mk(T, F, F, T, Z,     F, 0, T, T, ENT_A);
      vecs[4]  = mk(T, F, F, F, Z,     F, 0, T, T, ENT_A);
      vecs[5]  = mk(T, F, F, F, Z,     F, 0, T, F, ENT_A);
      vecs[6]  = mk(T, F, F, T, Z,     F, 0, T, F, ENT_A);
      vecs[7]  = mk(F, F, T, F, ENT_B, F, 1, T, T, ENT_A);
      vecs[8]  = mk(T, F, T, F, ENT_C, T, 1, T, T, ENT_B);
      vecs[9]  = mk(T, F, F, F, Z,     F, 1, T, T, ENT_B);
      vecs[10] = mk(T, F, F, T, Z,     F, 1, T, T, ENT_B);
      vecs[11] = mk(T, F, F, F, Z,     F, 1, T, T, ENT_B);
      vecs[12] = mk(T, F, F, F, Z,     F, 1, T, T, ENT_B);
      vecs[13] = mk(T, F, F, F, Z,     T, 0, T, T, ENT_C);
      vecs[14] = mk(T, F, T, F, ENT_D, F, 1, T, T, ENT_C);
      vecs[15] = mk(T, T, T, F, ENT_E, F, 0, T, T, ENT_C);
      vecs[16] = mk(T, F, F, T, Z,     F, 0, T, T, ENT_C);
      vecs[17] = mk(T, F, F, F, Z,     F, 0, T, T, ENT_C);
      vecs[18] = mk(T, F, F, F, Z,     F, 0, T, F, ENT_C);

      sys_rst_n = 1'b0;
      init_done = 1'b0;
      flush = 1'b0;
      req_valid = 1'b0;
      show_char_done = 1'b0;
      drive_entry(Z);
      tick();
      tick();
      check("rst_flag",  show_char_flag, 0);
      check("rst_ready", req_ready, 0);
      check("rst_level", level, 0);
      check("rst_busy",  busy, 0);
      check("rst_out",   out_fields(), 0);
      check("rst_terr",  timeout_err, 0);

      sys_rst_n = 1'b1;
      tick();
      check("ready_after_rst", req_ready, 1);
      init_done = 1'b1;
      tick();

      for (int i = 0; i < 19; i++) begin
         init_done      = vecs[i].init;
         flush          = vecs[i].flsh;
         req_valid      = vecs[i].valid;
         show_char_done = vecs[i].done;
         drive_entry(vecs[i].entry);
         tick();
         check($sformatf("v%0d_flag", i),  show_char_flag, vecs[i].exp_flag);
         check($sformatf("v%0d_level", i), level, vecs[i].exp_level);
         check($sformatf("v%0d_ready", i), req_ready, vecs[i].exp_ready);
         check($sformatf("v%0d_busy", i),  busy, vecs[i].exp_busy);
         check($sformatf("v%0d_out", i),   out_fields(), vecs[i].exp_out);
      end
      flush = 1'b0;
      req_valid = 1'b0;
      show_char_done = 1'b0;

      // Three queued while init is low, then issued in order with done + gap spacing.
      init_done = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         drive_entry(mk_ent(k));
         req_valid = 1'b1;
         tick();
         check("seqA_noissue", show_char_flag, 0);
      end
      req_valid = 1'b0;
      tick();
      check("seqA_level", level, 3);
      check("seqA_noissue_idle", show_char_flag, 0);
      init_done = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_flag("seqA_issue", n);
         check($sformatf("seqA_latency%0d", k), n, (k == 1) ? 1 : 3);
         check($sformatf("seqA_fields%0d", k), out_fields(), mk_ent(k));
         finish_char();
      end
      count_flags(6, cnt);
      check("seqA_extra_flags", cnt, 0);
      check("seqA_idle_busy", busy, 0);

      // Fill to DEPTH, reject one more, then drain exactly DEPTH.
      init_done = 1'b0;
      req_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive_entry(mk_ent(100 + k));
         tick();
      end
      check("seqB_full_level", level, 16);
      check("seqB_full_ready", req_ready, 0);
      drive_entry(mk_ent(200));
      tick();
      req_valid = 1'b0;
      check("seqB_overflow_level", level, 16);
      init_done = 1'b1;
      for (int k = 0; k < 16; k++) begin
         wait_flag("seqB_issue", n);
         check($sformatf("seqB_order%0d", k), out_fields(), mk_ent(100 + k));
         if (k == 0) check("seqB_ready_after_pop", req_ready, 1);
         finish_char();
      end
      count_flags(10, cnt);
      check("seqB_extra_flags", cnt, 0);
      check("seqB_empty_level", level, 0);

      // Flush during WAIT: queue cleared, in-flight fields held until done.
      init_done = 1'b0;
      req_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive_entry(mk_ent(20 + k));
         tick();
      end
      req_valid = 1'b0;
      init_done = 1'b1;
      wait_flag("seqC_issue", n);
      tick();
      check("seqC_level_before", level, 5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("seqC_level_flushed", level, 0);
      check("seqC_busy_inflight", busy, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("seqC_held", out_fields(), mk_ent(20));
      end
      show_char_done = 1'b1;
      tick();
      show_char_done = 1'b0;
      count_flags(10, cnt);
      check("seqC_no_more_flags", cnt, 0);
      check("seqC_busy_end", busy, 0);

`ifdef LCD_CHAR_QUEUE_TIMEOUT_EN
      drive_entry(mk_ent(40));
      req_valid = 1'b1;
      tick();
      drive_entry(mk_ent(41));
      tick();
      req_valid = 1'b0;
      check("seqD_issue", show_char_flag, 1);
      tick();
      n = 0;
      do begin
         tick();
         n++;
      end while (!timeout_err && n < 150);
      check("seqD_timeout_cycle", n, 100);
      wait_flag("seqD_next_issue", n);
      check("seqD_next_latency", n, 3);
      check("seqD_next_fields", out_fields(), mk_ent(41));
      finish_char();
      count_flags(5, cnt);
      check("seqD_sticky", timeout_err, 1);
`else
      check("terr_tied_low", timeout_err, 0);
`endif

      // Asynchronous reset while a character is in flight.
      drive_entry(mk_ent(50));
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_flag("seqE_issue", n);
      tick();
      drive_entry(mk_ent(51));
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("seqE_flag",  show_char_flag, 0);
      check("seqE_busy",  busy, 0);
      check("seqE_level", level, 0);
      check("seqE_out",   out_fields(), 0);
      sys_rst_n = 1'b1;
      count_flags(4, cnt);
      check("seqE_no_issue_after", cnt, 0);
      check("seqE_ready", req_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/lcd_char_queue.md
Name: lcd_char_queue

Overview:
- Buffered request queue between the menu/status display logic and the character renderer (lcd_show_char).
- Producers push character draw requests (glyph, position, size, colours) at any rate; the block stores them in a FIFO.
- It issues them one at a time using the renderer's flag/done handshake, and only once LCD init is complete.
- Decouples menu/key-event timing from slow SPI character drawing, so no key-driven redraw is lost.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- GAP_CYCLES, 2, idle sys_clk cycles inserted between done and the next issue.
- TIMEOUT_CYCLES, 2000000, watchdog limit in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock (PLL 100 MHz)
- sys_rst_n  in  1  asynchronous active-low reset
- init_done  in  1  LCD init complete; gates issuing
- flush  in  1  synchronous clear of queued (not in-flight) entries
- req_valid  in  1  producer request strobe
- req_ready  out  1  queue can accept (= not full)
- req_ascii  in  8  ASCII code
- req_x  in  9  start x
- req_y  in  9  start y
- req_size  in  1  0 = 12x6 font, 1 = 16x8 font
- req_fg  in  16  RGB565 front colour
- req_bg  in  16  RGB565 background colour
- show_char_done  in  1  renderer completion pulse
- show_char_flag  out  1  one-cycle issue pulse to renderer
- ascii_num  out  8; start_x  out  9; start_y  out  9; en_size  out  1; front_color  out  16; background_color  out  16 — held stable from issue until done
- level  out  $clog2(DEPTH+1)  entries stored
- busy  out  1  high in ISSUE/WAIT/GAP or level≠0
- timeout_err  out  1  sticky watchdog flag (0 when feature absent)

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Push: accepted when req_valid && req_ready. The entry is 59 bits {ascii,x,y,size,fg,bg}.
- Push while full: ignored, no overwrite.
- req_ready is registered from level; there is no same-cycle full bypass.
- FSM states:
  - IDLE: if init_done && level≠0 → pop head into output registers → ISSUE.
  - ISSUE: show_char_flag = 1 for exactly this cycle → WAIT.
  - WAIT: on show_char_done → GAP with counter = GAP_CYCLES.
  - GAP: count down → IDLE at 0.
- Latency: first issue pulse 2 cycles after push into an empty queue with init_done high (push cycle, IDLE pop, ISSUE).
- Output fields change only on an IDLE pop.
- show_char_done outside WAIT is ignored.
- Simultaneous push and pop: level unchanged; both take effect.
- flush: clears FIFO pointers and level next cycle.
  - A push in the same cycle is dropped (flush wins).
  - An in-flight character completes normally.
- init_done low: no new issue. An in-flight character still waits for done.
- Pointers wrap modulo DEPTH; level saturates by construction (never > DEPTH).
- Async reset mid-transfer: immediate return to IDLE, FIFO empty, flag low.

Optional Feature:
- Macro LCD_CHAR_QUEUE_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT. On reaching TIMEOUT_CYCLES without done, the FSM goes to GAP, drops the character, and sets timeout_err (sticky until reset).
- Undefined: no counter; WAIT is unbounded; timeout_err tied 0.

Decomposition:
- Shared package: entry field widths (ASCII_W=8, COORD_W=9, COLOR_W=16), ENTRY_W=59, FSM state encoding, font size constants.
- One sub-module: char_fifo_sync — a generic synchronous FIFO (DEPTH, WIDTH) with push/pop/flush/level. FSM and output registers stay in the top.

Test Plan:
- Reset, init_done=1, push 'A'(0x41) x=8 y=16 size=1 fg=0xFFFF bg=0x0000 → flag pulse 2 cycles later with exact fields; done → GAP 2 cycles → IDLE, busy=0.
- init_done=0, push 3 chars → level=3, no flag; raise init_done → 3 issues in push order, each only after the previous done + GAP.
- Push 16 with init_done=0 → req_ready=0, 17th push ignored, level=16; release → exactly 16 issues.
- Mid-WAIT flush with 5 queued → level=0 next cycle; in-flight char's fields held until done; no further flags.
- Same-cycle push and pop at level=1 → level stays 1; same-cycle push+flush → level 0.
- With LCD_CHAR_QUEUE_TIMEOUT_EN and TIMEOUT_CYCLES=100, withhold done → timeout_err=1 at cycle 100 of WAIT; next entry issues after GAP.
